// File: rtl/syn_down_cnt_if.sv
// Control and status bundle for syn_down_cnt. The master drives the controls and
// the counter (slave) returns its count and status flags.
interface syn_down_cnt_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             mode;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             tc;
  logic             done;
  logic [7:0]       wrap_cnt;

  modport master (
    output en, load, load_val, mode, start, stop,
    input  Q, busy, tc, done, wrap_cnt
  );

  modport slave (
    input  en, load, load_val, mode, start, stop,
    output Q, busy, tc, done, wrap_cnt
  );
endinterface

// File: rtl/syn_down_cnt.sv
// Loadable falling-edge down counter with one-shot/periodic modes, used as an interval timer.
// Define DOWN_CNT_WRAP_CNT_EN to build the saturating periodic-reload counter on wrap_cnt.
module syn_down_cnt #(
  parameter int WIDTH = 3
) (
  input logic         clk,
  input logic         rst,
  syn_down_cnt_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] toggle;
  logic             busy_r;
  logic             done_r;
  logic             q_zero;

  assign q_zero = (q == '0);

  // Bit i flips on a decrement only when every lower bit is zero (borrow ripples up).
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    logic chain;
    chain = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i] = chain;
      chain     = chain & ~q[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge clk) begin
    if (rst) begin
      q      <= '1;
      reload <= '1;
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.load) begin
        q      <= bus.load_val;
        reload <= bus.load_val;
        state  <= IDLE;
        busy_r <= 1'b0;
      end else if (bus.stop && state == RUN) begin
        state  <= IDLE;
        busy_r <= 1'b0;
      end else if (bus.start && state != RUN) begin
        if (state == DONE) q <= reload;
        state  <= RUN;
        busy_r <= 1'b1;
      end else if (state == RUN && bus.en) begin
        if (!q_zero) begin
          q <= q ^ toggle;
        end else if (!bus.mode) begin
          state  <= DONE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end else begin
          // Zero never wraps to all ones: periodic mode restarts from the reload value.
          q      <= reload;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign bus.Q    = q;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.tc   = (state == RUN) && q_zero;

`ifdef DOWN_CNT_WRAP_CNT_EN
  logic [7:0] wrap_q;
  logic       reload_evt;

  // Same condition as the periodic-reload branch above: load and stop both pre-empt it.
  assign reload_evt = (state == RUN) && !bus.load && !bus.stop && bus.en && q_zero && bus.mode;

  always_ff @(negedge clk) begin
    if (rst || bus.load) begin
      wrap_q <= '0;
    end else if (reload_evt && wrap_q != 8'hFF) begin
      wrap_q <= wrap_q + 8'd1;
    end
  end

  assign bus.wrap_cnt = wrap_q;
`else
  assign bus.wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_syn_down_cnt.sv
// Self-checking bench for syn_down_cnt: directed scenarios plus a randomized run
// compared against an arithmetic model of the counter's rules.
module tb_syn_down_cnt;

  localparam int W    = 3;
  localparam int MAXV = (1 << W) - 1;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_FIN  = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Reference model state
  int m_q;
  int m_rel;
  int m_st;
  int m_wrap;
  bit m_done;

  syn_down_cnt_if #(.WIDTH(W)) bus ();

  syn_down_cnt #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_wrap();
`ifdef DOWN_CNT_WRAP_CNT_EN
    return m_wrap;
`else
    return 0;
`endif
  endfunction

  // Apply one set of inputs across one falling edge, advancing the model alongside.
  task automatic tick(input bit r, input bit ld, input int lv, input bit md,
                      input bit st, input bit sp, input bit e);
    rst          = r;
    bus.load     = ld;
    bus.load_val = lv[W-1:0];
    bus.mode     = md;
    bus.start    = st;
    bus.stop     = sp;
    bus.en       = e;
    if (r) begin
      m_q = MAXV; m_rel = MAXV; m_st = S_IDLE; m_done = 0; m_wrap = 0;
    end else if (ld) begin
      m_q = lv % (MAXV + 1); m_rel = m_q; m_st = S_IDLE; m_done = 0; m_wrap = 0;
    end else if (sp && m_st == S_RUN) begin
      m_st = S_IDLE; m_done = 0;
    end else if (st && m_st != S_RUN) begin
      if (m_st == S_FIN) m_q = m_rel;
      m_st = S_RUN; m_done = 0;
    end else if (m_st == S_RUN && e) begin
      if (m_q > 0) begin
        m_q = m_q - 1; m_done = 0;
      end else if (!md) begin
        m_st = S_FIN; m_done = 1;
      end else begin
        m_q = m_rel; m_done = 1;
        m_wrap = (m_wrap < 255) ? m_wrap + 1 : 255;
      end
    end else begin
      m_done = 0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    total += 5;
    if (bus.Q !== 3'd7) begin bad++; $display("FAIL reset_q: got %0d expected 7", bus.Q); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    if (bus.tc !== 1'b0) begin bad++; $display("FAIL reset_tc: got %b expected 0", bus.tc); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    if (bus.wrap_cnt !== 8'd0) begin bad++; $display("FAIL reset_wrap: got %0d expected 0", bus.wrap_cnt); end
  endtask

  task automatic test_one_shot();
    tick(0, 1, 5, 0, 0, 0, 0);
    total++;
    if (bus.Q !== 3'd5) begin bad++; $display("FAIL os_load: got %0d expected 5", bus.Q); end
    tick(0, 0, 0, 0, 1, 0, 1);
    total += 2;
    if (bus.Q !== 3'd5) begin bad++; $display("FAIL os_start_q: got %0d expected 5", bus.Q); end
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL os_start_busy: got %b expected 1", bus.busy); end
    for (int v = 4; v >= 0; v--) begin
      tick(0, 0, 0, 0, 0, 0, 1);
      total += 3;
      if (bus.Q !== v[W-1:0]) begin bad++; $display("FAIL os_count: got %0d expected %0d", bus.Q, v); end
      if (bus.tc !== (v == 0)) begin bad++; $display("FAIL os_tc: got %b expected %b", bus.tc, v == 0); end
      if (bus.done !== 1'b0) begin bad++; $display("FAIL os_early_done: got %b expected 0", bus.done); end
    end
    tick(0, 0, 0, 0, 0, 0, 1);
    total += 4;
    if (bus.done !== 1'b1) begin bad++; $display("FAIL os_done: got %b expected 1", bus.done); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL os_done_busy: got %b expected 0", bus.busy); end
    if (bus.Q !== 3'd0) begin bad++; $display("FAIL os_done_q: got %0d expected 0", bus.Q); end
    if (bus.tc !== 1'b0) begin bad++; $display("FAIL os_done_tc: got %b expected 0", bus.tc); end
    tick(0, 0, 0, 0, 0, 0, 1);
    total += 2;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL os_done_single: got %b expected 0", bus.done); end
    if (bus.Q !== 3'd0) begin bad++; $display("FAIL os_hold: got %0d expected 0", bus.Q); end
    // Restart from DONE reloads the last loaded value
    tick(0, 0, 0, 0, 1, 0, 1);
    total += 2;
    if (bus.Q !== 3'd5) begin bad++; $display("FAIL os_restart_q: got %0d expected 5", bus.Q); end
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL os_restart_busy: got %b expected 1", bus.busy); end
  endtask

  task automatic test_periodic();
    tick(0, 1, 2, 1, 0, 0, 1);
    tick(0, 0, 0, 1, 1, 0, 1);
    total++;
    if (bus.Q !== 3'd2) begin bad++; $display("FAIL per_start: got %0d expected 2", bus.Q); end
    for (int i = 0; i < 9; i++) begin
      int eq;
      bit ed;
      eq = 2 - ((i + 1) % 3);
      ed = (i % 3 == 2);
      tick(0, 0, 0, 1, 0, 0, 1);
      total += 3;
      if (bus.Q !== eq[W-1:0]) begin bad++; $display("FAIL per_q: got %0d expected %0d", bus.Q, eq); end
      if (bus.done !== ed) begin bad++; $display("FAIL per_done: got %b expected %b", bus.done, ed); end
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL per_busy: got %b expected 1", bus.busy); end
      if (i == 5) begin
        int ew;
`ifdef DOWN_CNT_WRAP_CNT_EN
        ew = 2;
`else
        ew = 0;
`endif
        total++;
        if (bus.wrap_cnt !== ew[7:0]) begin bad++; $display("FAIL per_wrap: got %0d expected %0d", bus.wrap_cnt, ew); end
      end
    end
  endtask

  task automatic test_reload_zero();
    tick(0, 1, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 0, 0, 1);
      total += 3;
      if (bus.Q !== 3'd0) begin bad++; $display("FAIL rz_q: got %0d expected 0", bus.Q); end
      if (bus.done !== 1'b1) begin bad++; $display("FAIL rz_done: got %b expected 1", bus.done); end
      if (bus.tc !== 1'b1) begin bad++; $display("FAIL rz_tc: got %b expected 1", bus.tc); end
    end
  endtask

  task automatic test_enable();
    int ens[4] = '{1, 0, 0, 1};
    int eqs[4] = '{5, 5, 5, 4};
    tick(0, 1, 6, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 0, 0, ens[i] != 0);
      total++;
      if (bus.Q !== eqs[i][W-1:0]) begin bad++; $display("FAIL en_gate: got %0d expected %0d", bus.Q, eqs[i]); end
    end
  endtask

  // Continues from test_enable: running with Q = 4
  task automatic test_priority();
    tick(0, 0, 0, 0, 1, 1, 1);
    total += 2;
    if (bus.Q !== 3'd4) begin bad++; $display("FAIL pri_stop_q: got %0d expected 4", bus.Q); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL pri_stop_busy: got %b expected 0", bus.busy); end
    tick(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (bus.Q !== 3'd4) begin bad++; $display("FAIL pri_idle_hold: got %0d expected 4", bus.Q); end
    tick(0, 0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
    total += 2;
    if (bus.Q !== 3'd2) begin bad++; $display("FAIL pri_resume: got %0d expected 2", bus.Q); end
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL pri_resume_busy: got %b expected 1", bus.busy); end
    tick(0, 1, 3, 0, 1, 0, 1);
    total += 2;
    if (bus.Q !== 3'd3) begin bad++; $display("FAIL pri_load_q: got %0d expected 3", bus.Q); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL pri_load_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_mid_reset();
    tick(0, 1, 2, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (bus.Q !== 3'd1) begin bad++; $display("FAIL mr_setup: got %0d expected 1", bus.Q); end
    tick(1, 0, 0, 0, 0, 0, 1);
    total += 3;
    if (bus.Q !== 3'd7) begin bad++; $display("FAIL mr_q: got %0d expected 7", bus.Q); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL mr_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL mr_done: got %b expected 0", bus.done); end
    tick(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL mr_done_after: got %b expected 0", bus.done); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit r, ld, st, sp, e, md;
      int lv, ew;
      r  = ($urandom_range(63) == 0);
      ld = ($urandom_range(15) == 0);
      sp = ($urandom_range(15) == 0);
      st = ($urandom_range(7) == 0);
      e  = ($urandom_range(3) != 0);
      md = $urandom_range(1);
      lv = $urandom_range(MAXV);
      tick(r, ld, lv, md, st, sp, e);
      ew = exp_wrap();
      total += 5;
      if (bus.Q !== m_q[W-1:0]) begin bad++; $display("FAIL rnd_q @%0d: got %0d expected %0d", i, bus.Q, m_q); end
      if (bus.busy !== (m_st == S_RUN)) begin bad++; $display("FAIL rnd_busy @%0d: got %b expected %b", i, bus.busy, m_st == S_RUN); end
      if (bus.tc !== (m_st == S_RUN && m_q == 0)) begin bad++; $display("FAIL rnd_tc @%0d: got %b expected %b", i, bus.tc, m_st == S_RUN && m_q == 0); end
      if (bus.done !== m_done) begin bad++; $display("FAIL rnd_done @%0d: got %b expected %b", i, bus.done, m_done); end
      if (bus.wrap_cnt !== ew[7:0]) begin bad++; $display("FAIL rnd_wrap @%0d: got %0d expected %0d", i, bus.wrap_cnt, ew); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.mode     = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    m_q = MAXV; m_rel = MAXV; m_st = S_IDLE; m_done = 0; m_wrap = 0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_reload_zero();
    test_enable();
    test_priority();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/syn_down_cnt.md
Name: syn_down_cnt

Overview:
- Parameterised synchronous down counter with load, enable, one-shot/periodic modes, terminal-count flag and a done pulse.
- Complements the team's 3-bit synchronous up counter: same falling-edge timing, same toggle-chain construction, opposite count direction.
- Used as a loadable interval/delay timer feeding control FSMs elsewhere in the design.

Parameters:
- WIDTH, 3, counter width in bits (legal range 2..16).

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  count enable; decrement only when high in RUN.
- load  input  1  load Q and reload register from load_val.
- load_val  input  WIDTH  value for load and for periodic reload.
- mode  input  1  0 = one-shot, 1 = periodic; sampled every edge.
- start  input  1  IDLE/DONE -> RUN request.
- stop  input  1  RUN -> IDLE, Q held.
- Q  output  WIDTH  current count.
- busy  output  1  high while state = RUN (registered).
- tc  output  1  combinational: (state == RUN) && (Q == 0).
- done  output  1  registered one-cycle pulse on terminal count.
- wrap_cnt  output  8  reload counter (see Optional Feature).

Behaviour:
- Reset (rst high at a falling edge):
  - Q = all ones (7 for WIDTH=3); reload register = all ones.
  - State IDLE; busy = 0, done = 0, wrap_cnt = 0.
- Priority at each edge: rst > load > stop > start > count.
- States:
  - IDLE: Q holds.
    - start -> RUN; the first decrement happens on the following edge.
  - RUN, en = 0: Q holds; tc may stay high.
  - RUN, en = 1, Q != 0: Q <= Q - 1.
  - RUN, en = 1, Q == 0, mode = 0: next state DONE, Q stays 0, done = 1 for one cycle.
  - RUN, en = 1, Q == 0, mode = 1: Q <= reload register, stay in RUN, done = 1 for one cycle.
  - DONE: Q holds at 0; busy = 0.
    - start -> Q <= reload register, state RUN.
- load (any state): Q <= load_val, reload register <= load_val, state IDLE, done = 0.
- stop: honoured in RUN only; ignored in other states.
- start while in RUN: ignored.
- Decrement must be built as a toggle chain, not an adder:
  - toggle[0] = 1.
  - toggle[i] = ~Q[0] & ... & ~Q[i-1].
  - Q <= Q ^ toggle when decrementing.
- Wrap-around: the all-zero state never decrements to all ones. It reloads (periodic) or stops (one-shot).
- Reload value 0 in periodic mode: Q stays 0, and done pulses on every enabled edge.
- done is never high for two consecutive cycles, except in the reload-0 periodic case above.
- busy is registered and follows the state.
- Mid-operation events:
  - rst or load in RUN: takes effect on that edge; no done pulse is generated.
  - mode changes in RUN: take effect at the next Q == 0 event.

Optional Feature:
- Macro: DOWN_CNT_WRAP_CNT_EN.
- Defined: wrap_cnt increments on each periodic reload (mode = 1, Q == 0, en = 1, in RUN).
  - Saturates at 255.
  - Cleared by rst and load.
- Undefined: wrap_cnt tied to 0; no counter logic is synthesised. The port list is identical in both builds.

Test Plan:
- Reset: rst high for 2 falling edges -> Q = 7, busy = 0, tc = 0, done = 0, wrap_cnt = 0.
- One-shot:
  - Stimulus: load_val = 5, load; then start, en = 1, mode = 0.
  - Response: Q = 5,4,3,2,1,0 on successive edges; tc = 1 while Q = 0 in RUN; then DONE with a single done pulse, busy = 0, Q holds 0.
- Periodic:
  - Stimulus: load_val = 2, mode = 1, en = 1, run 9 edges.
  - Response: Q = 2,1,0,2,1,0,2,1,0; done pulses each time 0 reloads to 2.
  - Macro defined: wrap_cnt = 2 after the second reload.
- Enable gating: en toggled 1,0,0,1 from Q = 6 -> Q = 5,5,5,4.
- Priority:
  - load and start together in RUN with load_val = 3 -> Q = 3, state IDLE.
  - stop at Q = 4 -> IDLE with Q = 4.
  - A later start resumes at 4,3,...
- Mid-count reset: rst at Q = 1 in RUN -> next Q = 7, IDLE, and no done pulse.
